// File: rtl/pixel_ctrl_pkg.sv
// pixel_ctrl_pkg: shared state type, default phase lengths and Gray helpers for pixel_array_ctrl
//   Contents: pixel_ctrl_state_t, DEF_* phase-length defaults, bin2gray/gray2bin.
//   The Gray helpers work on a GRAY_W-wide container; callers zero-extend their
//   DATA_W value in and truncate the result back to DATA_W.
package pixel_ctrl_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERASE,
      ST_EXPOSE,
      ST_CONVERT,
      ST_SETTLE,
      ST_STREAM
   } pixel_ctrl_state_t;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_ERASE_CYC  = 5;
   localparam int DEF_EXPOSE_CYC = 255;
   localparam int DEF_SETTLE_CYC = 2;
   localparam int GRAY_W         = 32;
   function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
      return b ^ (b >> 1);
   endfunction
   // Zero upper bits of a zero-extended code leave the low DATA_W bits exact.
   function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
      logic [GRAY_W-1:0] b;
      b = g;
      for (int i = 1; i < GRAY_W; i++) b = b ^ (g >> i);
      return b;
   endfunction
endpackage

// File: rtl/pixel_conv_counter.sv
// pixel_conv_counter: DATA_W-bit conversion ramp counter with clear, enable and terminal count
//   Build option: PIXEL_CTRL_GRAY_EN makes cnt_o carry the Gray code of the count.
//   Ports:
//     clk_i, reset_i : clock, synchronous active-high reset
//     clr_i          : force count to zero (wins over en_i)
//     en_i           : advance count by one
//     cnt_o          : registered count (binary or Gray)
//     tc_o           : binary count is at its maximum
module pixel_conv_counter import pixel_ctrl_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clr_i,
   input  logic              en_i,
   output logic [DATA_W-1:0] cnt_o,
   output logic              tc_o
);
   logic [DATA_W-1:0] cnt_q, cnt_d;
   assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
   assign tc_o  = (cnt_q == '1);
   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
`ifdef PIXEL_CTRL_GRAY_EN
   // Encoded from the next count so the bus value is a flop, in step with cnt_q.
   logic [DATA_W-1:0] gray_q;
   always_ff @(posedge clk_i) begin
      if (reset_i) gray_q <= '0;
      else gray_q <= DATA_W'(bin2gray(GRAY_W'(cnt_d)));
   end
   assign cnt_o = gray_q;
`else
   assign cnt_o = cnt_q;
`endif
endmodule

// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl: ERASE/EXPOSE/CONVERT/READ sequencer for a 4-pixel array with captured-code streaming
//   Build option: PIXEL_CTRL_GRAY_EN drives a Gray count and decodes captures back to binary.
//   Ports:
//     clk_i, reset_i                  : clock, synchronous active-high reset
//     start_i                         : frame request, honoured only in IDLE
//     erase_o/expose_o/convert_o/read_o : pixel phase controls (mutually exclusive)
//     cnt_out_o, cnt_oe_o             : conversion count and its bus output-enable
//     pix_data1_i..pix_data4_i        : latched pixel codes seen on the array buses
//     px_data_o, px_idx_o, px_valid_o, px_ready_i : downstream pixel stream
//     busy_o, frame_done_o            : not-IDLE flag, end-of-frame pulse
module pixel_array_ctrl import pixel_ctrl_pkg::*; #(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ERASE_CYC  = DEF_ERASE_CYC,
   parameter int EXPOSE_CYC = DEF_EXPOSE_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   output logic              erase_o,
   output logic              expose_o,
   output logic              convert_o,
   output logic              read_o,
   output logic [DATA_W-1:0] cnt_out_o,
   output logic              cnt_oe_o,
   input  logic [DATA_W-1:0] pix_data1_i,
   input  logic [DATA_W-1:0] pix_data2_i,
   input  logic [DATA_W-1:0] pix_data3_i,
   input  logic [DATA_W-1:0] pix_data4_i,
   output logic [DATA_W-1:0] px_data_o,
   output logic [1:0]        px_idx_o,
   output logic              px_valid_o,
   input  logic              px_ready_i,
   output logic              busy_o,
   output logic              frame_done_o
);
   localparam int MAX_CYC = (ERASE_CYC > EXPOSE_CYC)
      ? ((ERASE_CYC > SETTLE_CYC) ? ERASE_CYC : SETTLE_CYC)
      : ((EXPOSE_CYC > SETTLE_CYC) ? EXPOSE_CYC : SETTLE_CYC);
   localparam int TW = $clog2(MAX_CYC + 1);
   pixel_ctrl_state_t      state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [3:0][DATA_W-1:0] cap_q, cap_d;
   logic [1:0]             idx_q, idx_d;
   logic [DATA_W-1:0]      data_q, data_d, cap_sel;
   logic erase_q, expose_q, convert_q, read_q, valid_q, busy_q, done_q;
   logic xfer, last_xfer, timed, capture, cnt_tc;
   assign xfer      = valid_q & px_ready_i;
   assign last_xfer = xfer & (idx_q == 2'd3);
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    state_d = start_i ? ST_ERASE : ST_IDLE;
         ST_ERASE:   state_d = (timer_q == TW'(ERASE_CYC - 1)) ? ST_EXPOSE : ST_ERASE;
         ST_EXPOSE:  state_d = (timer_q == TW'(EXPOSE_CYC - 1)) ? ST_CONVERT : ST_EXPOSE;
         ST_CONVERT: state_d = cnt_tc ? ST_SETTLE : ST_CONVERT;
         ST_SETTLE:  state_d = (timer_q == TW'(SETTLE_CYC - 1)) ? ST_STREAM : ST_SETTLE;
         ST_STREAM:  state_d = last_xfer ? ST_IDLE : ST_STREAM;
         default:    state_d = ST_IDLE;
      endcase
   end
   // One shared phase timer, restarted on every state change.
   assign timed   = (state_q == ST_ERASE) || (state_q == ST_EXPOSE) || (state_q == ST_SETTLE);
   assign timer_d = (timed && state_d == state_q) ? timer_q + 1'b1 : '0;
   assign capture = (state_q == ST_SETTLE) && (state_d == ST_STREAM);
   assign cap_d   = capture ? {pix_data4_i, pix_data3_i, pix_data2_i, pix_data1_i} : cap_q;
   assign idx_d   = (state_d == ST_STREAM) ? idx_q + {1'b0, xfer} : 2'd0;
   // Select from cap_d so idx 0 is presented in the first STREAM cycle.
   assign cap_sel = cap_d[idx_d];
`ifdef PIXEL_CTRL_GRAY_EN
   assign data_d = (state_d == ST_STREAM) ? DATA_W'(gray2bin(GRAY_W'(cap_sel))) : '0;
`else
   assign data_d = (state_d == ST_STREAM) ? cap_sel : '0;
`endif
   // Counter is held clear outside CONVERT so the first CONVERT cycle shows 0.
   pixel_conv_counter #(.DATA_W(DATA_W)) u_cnt (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .clr_i  (state_d != ST_CONVERT),
      .en_i   (state_q == ST_CONVERT),
      .cnt_o  (cnt_out_o),
      .tc_o   (cnt_tc)
   );
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         cap_q     <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         erase_q   <= 1'b0;
         expose_q  <= 1'b0;
         convert_q <= 1'b0;
         read_q    <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         cap_q     <= cap_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         erase_q   <= (state_d == ST_ERASE);
         expose_q  <= (state_d == ST_EXPOSE);
         convert_q <= (state_d == ST_CONVERT);
         read_q    <= (state_d == ST_SETTLE);
         valid_q   <= (state_d == ST_STREAM);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_q == ST_STREAM) && last_xfer;
      end
   end
   assign erase_o      = erase_q;
   assign expose_o     = expose_q;
   assign convert_o    = convert_q;
   assign cnt_oe_o     = convert_q;
   assign read_o       = read_q;
   assign px_valid_o   = valid_q;
   assign px_idx_o     = idx_q;
   assign px_data_o    = data_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;
endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb_pixel_array_ctrl: table-driven frames, corner sequences and random-ready frames against a timeline model
module tb_pixel_array_ctrl;
   localparam int E   = 5;
   localparam int X   = 255;
   localparam int C   = 256;
   localparam int S   = 2;
   localparam int LAT = 1 + E + X + C + S;
   logic clk = 1'b0;
   logic reset, start, px_ready;
   logic erase_o, expose_o, convert_o, read_o, cnt_oe_o, px_valid_o, busy_o, frame_done_o;
   logic [7:0] cnt_out_o, px_data_o;
   logic [1:0] px_idx_o;
   logic [7:0] pix1, pix2, pix3, pix4;
   logic [3:0][7:0] cur_codes;
   logic [25:0] out_vec;
   int checks = 0, failures = 0;
   bit chk_en = 0;
   bit rdy_mode = 0;
   int stall_idx = -1, stall_left = 0;
   int n_erase, n_expose, n_conv, n_read;
   logic [7:0] got[$];
   bit m_act = 0, m_done = 0;
   int m_t = 0, m_idx = 0;
   logic [3:0][7:0] m_cap = '0;
   typedef struct {
      logic [3:0][7:0] codes;
      int s_idx;
      int s_len;
      bit mid;
      int exp_done;
   } vec_t;
   vec_t vecs[5];
   always #5 clk = ~clk;
   function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef PIXEL_CTRL_GRAY_EN
      return v ^ (v >> 1);
`else
      return v;
`endif
   endfunction
   assign pix1 = enc(cur_codes[0]);
   assign pix2 = enc(cur_codes[1]);
   assign pix3 = enc(cur_codes[2]);
   assign pix4 = enc(cur_codes[3]);
   assign out_vec = {erase_o, expose_o, convert_o, read_o, cnt_oe_o, busy_o, frame_done_o,
                     px_valid_o, px_idx_o, cnt_out_o, px_data_o};
   pixel_array_ctrl #(.DATA_W(8), .ERASE_CYC(E), .EXPOSE_CYC(X), .SETTLE_CYC(S)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start),
      .erase_o(erase_o), .expose_o(expose_o), .convert_o(convert_o), .read_o(read_o),
      .cnt_out_o(cnt_out_o), .cnt_oe_o(cnt_oe_o),
      .pix_data1_i(pix1), .pix_data2_i(pix2), .pix_data3_i(pix3), .pix_data4_i(pix4),
      .px_data_o(px_data_o), .px_idx_o(px_idx_o), .px_valid_o(px_valid_o), .px_ready_i(px_ready),
      .busy_o(busy_o), .frame_done_o(frame_done_o)
   );
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask
   // Timeline model: t counts cycles since the accepted start; stream position tracked separately.
   always @(posedge clk) begin
      if (reset) begin
         m_act = 0; m_t = 0; m_idx = 0; m_done = 0; m_cap = '0;
      end else begin
         m_done = 0;
         if (!m_act) begin
            if (start) begin m_act = 1; m_t = 1; m_idx = 0; end
         end else if (m_t < LAT) begin
            if (m_t == LAT - 1) m_cap = cur_codes;
            m_t++;
         end else if (px_ready) begin
            if (m_idx == 3) begin m_act = 0; m_done = 1; end
            else m_idx++;
         end
      end
   end
   always @(negedge clk) begin
      bit e_er, e_ex, e_cv, e_rd, e_v;
      logic [25:0] exp_v;
      if (chk_en) begin
         e_er = m_act && m_t >= 1 && m_t <= E;
         e_ex = m_act && m_t >= E + 1 && m_t <= E + X;
         e_cv = m_act && m_t >= E + X + 1 && m_t <= E + X + C;
         e_rd = m_act && m_t >= E + X + C + 1 && m_t <= E + X + C + S;
         e_v  = m_act && m_t == LAT;
         exp_v = {e_er, e_ex, e_cv, e_rd, e_cv, m_act, m_done, e_v,
                  e_v ? 2'(m_idx) : 2'd0,
                  e_cv ? enc(8'(m_t - (E + X + 1))) : 8'd0,
                  e_v ? m_cap[m_idx] : 8'd0};
         check("outputs", 64'(out_vec), 64'(exp_v));
         check("phase_onehot", 64'($onehot0({erase_o, expose_o, convert_o, read_o})), 64'd1);
         if (erase_o) n_erase++;
         if (expose_o) n_expose++;
         if (convert_o) n_conv++;
         if (read_o) n_read++;
      end
      if (rdy_mode) px_ready = 1'($urandom_range(0, 1));
      else if (px_valid_o && int'(px_idx_o) == stall_idx && stall_left > 0) begin
         px_ready = 1'b0;
         stall_left--;
      end else px_ready = 1'b1;
      if (chk_en && px_valid_o === 1'b1 && px_ready) begin
         check("idx_order", 64'(px_idx_o), 64'(got.size()));
         got.push_back(px_data_o);
      end
   end
   task automatic run_frame(input vec_t v);
      int n;
      bit seen;
      cur_codes = v.codes;
      stall_idx = v.s_idx;
      stall_left = v.s_len;
      got.delete();
      n_erase = 0; n_expose = 0; n_conv = 0; n_read = 0;
      @(negedge clk);
      start = 1'b1;
      n = 0;
      seen = 0;
      while (n < 3000 && !seen) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (v.mid && (n == 100 || n == LAT)) start = 1'b1;
         if (v.mid && (n == 101 || n == LAT + 1)) start = 1'b0;
`ifdef PIXEL_CTRL_GRAY_EN
         if (n == E + X + 1 + 3) check("gray_cnt3", 64'(cnt_out_o), 64'h02);
         if (n == E + X + 1 + 255) check("gray_cnt255", 64'(cnt_out_o), 64'h80);
`endif
         seen = frame_done_o;
      end
      start = 1'b0;
      check("done_seen", 64'(seen), 64'd1);
      if (v.exp_done > 0) check("done_cycle", 64'(n), 64'(v.exp_done));
      check("erase_len", 64'(n_erase), 64'(E));
      check("expose_len", 64'(n_expose), 64'(X));
      check("convert_len", 64'(n_conv), 64'(C));
      check("read_len", 64'(n_read), 64'(S));
      check("stream_count", 64'(got.size()), 64'd4);
      for (int i = 0; i < 4 && i < got.size(); i++) check("stream_data", 64'(got[i]), 64'(v.codes[i]));
      if (v.mid) begin
         repeat (20) @(negedge clk);
         check("no_restart", 64'(busy_o), 64'd0);
      end
   endtask
   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      vec_t rv;
      vecs[0] = '{codes: 32'hE6B38033, s_idx: -1, s_len: 0, mid: 0, exp_done: LAT + 4};
      vecs[1] = '{codes: 32'h11223344, s_idx: 1, s_len: 4, mid: 0, exp_done: LAT + 8};
      vecs[2] = '{codes: 32'h7F01FF00, s_idx: -1, s_len: 0, mid: 1, exp_done: LAT + 4};
      vecs[3] = '{codes: 32'h78563412, s_idx: 3, s_len: 2, mid: 0, exp_done: LAT + 6};
      vecs[4] = '{codes: 32'hA5C3F00F, s_idx: 0, s_len: 1, mid: 0, exp_done: LAT + 5};
      reset = 1'b1;
      start = 1'b0;
      px_ready = 1'b1;
      cur_codes = '0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("reset_state", 64'(out_vec), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) run_frame(vecs[i]);
      cur_codes = 32'h0A0B0C0D;
      got.delete();
      @(negedge clk);
      start = 1'b1;
      for (int n = 1; n <= E + X + 100; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
      end
      check("mid_convert_cnt", 64'({convert_o, cnt_out_o}), 64'({1'b1, enc(8'd99)}));
      reset = 1'b1;
      @(negedge clk);
      check("reset_outputs", 64'(out_vec), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      reset = 1'b0;
      run_frame(vecs[0]);
      rdy_mode = 1;
      for (int i = 0; i < 3; i++) begin
         rv = '{codes: 32'($urandom), s_idx: -1, s_len: 0, mid: 0, exp_done: 0};
         run_frame(rv);
      end
      rdy_mode = 0;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
